// File: rtl/mips_mem_pkg.sv
// Shared memory-access types for the CPU decoder and the memory-port controller:
// access sizes, controller state codes and the alignment rule.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } mem_size_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_CMD  = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_CMD  = 3'd3,
    ST_DONE    = 3'd4
  } mem_state_t;

  // True when the access cannot be issued as a single bus transfer.
  function automatic logic misaligned(mem_size_t size, logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return off[0];
      WORD:    return |off;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/acknowledge and Avalon-MM signals of the memory-port controller.
// master = the controller itself; slave = decoder plus memory side.
interface mem_bus_ctrl_if;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        req_err;
  logic        bus_err;
  logic        stall;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  avm_readdata, avm_waitrequest,
    output ack, rdata, req_err, bus_err, stall,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output avm_readdata, avm_waitrequest,
    input  ack, rdata, req_err, bus_err, stall,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: store data/byteenable towards the bus and
// lane extraction plus sign/zero extension of load data.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  mem_size_t   size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic        is_signed,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_lanes,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = rdata_raw[8*gi +: 8];
  end

  always_comb begin
    byteenable  = 4'b0000;
    wdata_lanes = 32'h0;
    rdata_ext   = rdata_raw;
    sel_byte    = rd_byte[offset];
    sel_half    = offset[1] ? {rd_byte[3], rd_byte[2]} : {rd_byte[1], rd_byte[0]};
    case (size)
      BYTE: begin
        byteenable  = 4'b0001 << offset;
        wdata_lanes = {4{wdata[7:0]}};
        rdata_ext   = {{24{is_signed & sel_byte[7]}}, sel_byte};
      end
      HALF: begin
        byteenable  = offset[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        rdata_ext   = {{16{is_signed & sel_half[15]}}, sel_half};
      end
      WORD: begin
        byteenable  = 4'b1111;
        wdata_lanes = wdata;
      end
      default: begin
        byteenable  = 4'b0000;
        wdata_lanes = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Multicycle controller between the CPU decoder and one Avalon-MM memory port.
// Optional bus timeout abort: define MEM_BUS_CTRL_TIMEOUT_EN.
module mem_bus_ctrl
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            Rst,
  mem_bus_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RD_CMD  = ST_RD_CMD;
  localparam logic [2:0] S_RD_DATA = ST_RD_DATA;
  localparam logic [2:0] S_WR_CMD  = ST_WR_CMD;
  localparam logic [2:0] S_DONE    = ST_DONE;

  logic [2:0]  state_q, state_d;
  mem_size_t   size_q, size_d;
  logic [1:0]  off_q, off_d;
  logic        signed_q, signed_d;
  logic [31:0] avm_address_q, avm_address_d;
  logic        avm_read_q, avm_read_d;
  logic        avm_write_q, avm_write_d;
  logic [31:0] avm_writedata_q, avm_writedata_d;
  logic [3:0]  avm_byteenable_q, avm_byteenable_d;
  logic        ack_q, ack_d;
  logic        req_err_q, req_err_d;
  logic [31:0] rdata_q, rdata_d;

  mem_size_t   req_size_e;
  mem_size_t   align_size;
  logic [1:0]  align_off;
  logic [3:0]  align_be;
  logic [31:0] align_wdata;
  logic [31:0] align_rdata;

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
  logic            bus_err_q, bus_err_d;
  assign bus.bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign bus.bus_err    = 1'b0;
`endif

  assign req_size_e = mem_size_t'(bus.req_size);

  // In IDLE the aligner steers the incoming request; afterwards it sees the latched one.
  assign align_size = (state_q == S_IDLE) ? req_size_e : size_q;
  assign align_off  = (state_q == S_IDLE) ? bus.req_addr[1:0] : off_q;

  mem_lane_align u_align (
    .size        (align_size),
    .offset      (align_off),
    .wdata       (bus.req_wdata),
    .is_signed   (signed_q),
    .rdata_raw   (bus.avm_readdata),
    .byteenable  (align_be),
    .wdata_lanes (align_wdata),
    .rdata_ext   (align_rdata)
  );

  always_comb begin
    state_d          = state_q;
    size_d           = size_q;
    off_d            = off_q;
    signed_d         = signed_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_writedata_d  = avm_writedata_q;
    avm_byteenable_d = avm_byteenable_q;
    ack_d            = 1'b0;
    req_err_d        = 1'b0;
    rdata_d          = rdata_q;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    wait_cnt_d       = wait_cnt_q;
    bus_err_d        = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
        if (bus.req_valid) begin
          size_d   = req_size_e;
          off_d    = bus.req_addr[1:0];
          signed_d = bus.req_signed;
          if (misaligned(req_size_e, bus.req_addr[1:0])) begin
            state_d   = S_DONE;
            ack_d     = 1'b1;
            req_err_d = 1'b1;
          end else begin
            avm_address_d    = {bus.req_addr[31:2], 2'b00};
            avm_byteenable_d = align_be;
            avm_writedata_d  = align_wdata;
            avm_write_d      = bus.req_write;
            avm_read_d       = ~bus.req_write;
            state_d          = bus.req_write ? S_WR_CMD : S_RD_CMD;
          end
        end
      end
      S_RD_CMD, S_WR_CMD: begin
        if (!bus.avm_waitrequest) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          if (state_q == S_RD_CMD) begin
            state_d = S_RD_DATA;
          end else begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end
        end
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
        else if (wait_cnt_q == TO_LAST) begin
          avm_read_d  = 1'b0;
          avm_write_d = 1'b0;
          state_d     = S_DONE;
          ack_d       = 1'b1;
          bus_err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + TO_W'(1);
        end
`endif
      end
      S_RD_DATA: begin
        rdata_d = align_rdata;
        state_d = S_DONE;
        ack_d   = 1'b1;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        avm_read_d  = 1'b0;
        avm_write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q          <= S_IDLE;
      size_q           <= BYTE;
      off_q            <= 2'b00;
      signed_q         <= 1'b0;
      avm_address_q    <= 32'h0;
      avm_read_q       <= 1'b0;
      avm_write_q      <= 1'b0;
      avm_writedata_q  <= 32'h0;
      avm_byteenable_q <= 4'b0000;
      ack_q            <= 1'b0;
      req_err_q        <= 1'b0;
      rdata_q          <= 32'h0;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      wait_cnt_q       <= '0;
      bus_err_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      size_q           <= size_d;
      off_q            <= off_d;
      signed_q         <= signed_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_writedata_q  <= avm_writedata_d;
      avm_byteenable_q <= avm_byteenable_d;
      ack_q            <= ack_d;
      req_err_q        <= req_err_d;
      rdata_q          <= rdata_d;
`ifdef MEM_BUS_CTRL_TIMEOUT_EN
      wait_cnt_q       <= wait_cnt_d;
      bus_err_q        <= bus_err_d;
`endif
    end
  end

  assign bus.ack            = ack_q;
  assign bus.req_err        = req_err_q;
  assign bus.rdata          = rdata_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_read       = avm_read_q;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_writedata  = avm_writedata_q;
  assign bus.avm_byteenable = avm_byteenable_q;
  // The decoder must see the stall in the same cycle it presents the request.
  assign bus.stall          = bus.req_valid & ~ack_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl: directed cases, randomized requests
// against a little-endian memory-access model, reset abort and optional timeout.
module tb_mem_bus_ctrl;

  logic clk = 1'b0;
  logic Rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_rdata = 32'h0;

  mem_bus_ctrl_if bif ();

  mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] addr);
    return (sz == 2'd3) || (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    return 4'(1 << off);
      2'd1:    return 4'(3 << off);
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg,
                                             input logic [1:0] off, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * off);
    if (sz == 2'd0) begin
      v = v % 256;
      if (sg && v >= 128) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (sg && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input int nwait,
                        input logic [31:0] rword, input logic scramble);
    logic        err;
    logic [3:0]  be;
    logic [31:0] mask;
    int          ack_cyc;
    logic        got_ack;
    logic        cmd;
    err     = model_err(sz, addr);
    be      = model_be(sz, addr[1:0]);
    mask    = 32'h0;
    for (int i = 0; i < 4; i++) if (be[i]) mask = mask | (32'hFF << (8 * i));
    ack_cyc = err ? 1 : (wr ? 2 + nwait : 3 + nwait);
    got_ack = 1'b0;
    @(negedge clk);
    bif.req_valid  = 1'b1;
    bif.req_write  = wr;
    bif.req_size   = sz;
    bif.req_signed = sg;
    bif.req_addr   = addr;
    bif.req_wdata  = wd;
    for (int c = 1; c <= 40 && !got_ack; c++) begin
      @(negedge clk);
      cmd = !err && (c <= nwait + 1);
      chk({tag, ".avm_read"}, 32'(bif.avm_read), 32'(cmd && !wr));
      chk({tag, ".avm_write"}, 32'(bif.avm_write), 32'(cmd && wr));
      if (cmd) begin
        chk({tag, ".address"}, bif.avm_address, addr & 32'hFFFFFFFC);
        chk({tag, ".byteenable"}, 32'(bif.avm_byteenable), 32'(be));
        if (wr) chk({tag, ".writedata"}, bif.avm_writedata & mask, (wd << (8 * addr[1:0])) & mask);
      end
      chk({tag, ".stall"}, 32'(bif.stall), 32'(c != ack_cyc));
      if (bif.ack) begin
        got_ack = 1'b1;
        if (!err && !wr) exp_rdata = model_load(sz, sg, addr[1:0], rword);
        chk({tag, ".ack_cycle"}, 32'(c), 32'(ack_cyc));
        chk({tag, ".req_err"}, 32'(bif.req_err), 32'(err));
        chk({tag, ".bus_err"}, 32'(bif.bus_err), 32'h0);
        chk({tag, ".rdata"}, bif.rdata, exp_rdata);
        bif.req_valid = 1'b0;
      end
      bif.avm_waitrequest = cmd && (c <= nwait);
      bif.avm_readdata    = (!wr && c == nwait + 2) ? rword : $urandom;
      if (scramble && c == 1) begin
        bif.req_write  = 1'($urandom);
        bif.req_size   = 2'($urandom);
        bif.req_signed = 1'($urandom);
        bif.req_addr   = $urandom;
        bif.req_wdata  = $urandom;
      end
    end
    if (!got_ack) chk({tag, ".ack_missing"}, 32'h0, 32'h1);
    $display("txn %s wr=%0d size=%0d addr=%h wait=%0d rdata=%h", tag, wr, sz, addr, nwait, bif.rdata);
  endtask

  initial begin
    bif.req_valid       = 1'b0;
    bif.req_write       = 1'b0;
    bif.req_size        = 2'd0;
    bif.req_signed      = 1'b0;
    bif.req_addr        = 32'h0;
    bif.req_wdata       = 32'h0;
    bif.avm_readdata    = 32'h0;
    bif.avm_waitrequest = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst.avm_read", 32'(bif.avm_read), 32'h0);
    chk("rst.avm_write", 32'(bif.avm_write), 32'h0);
    chk("rst.ack", 32'(bif.ack), 32'h0);
    chk("rst.req_err", 32'(bif.req_err), 32'h0);
    chk("rst.bus_err", 32'(bif.bus_err), 32'h0);
    chk("rst.byteenable", 32'(bif.avm_byteenable), 32'h0);
    chk("rst.address", bif.avm_address, 32'h0);
    chk("rst.rdata", bif.rdata, 32'h0);
    Rst = 1'b0;

    do_req("lw_1004", 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    chk("lw_1004.value", bif.rdata, 32'hDEADBEEF);
    do_req("lb_2003", 1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 0, 32'h80112233, 1'b0);
    chk("lb_2003.value", bif.rdata, 32'hFFFFFF80);
    do_req("lbu_2003", 1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 0, 32'h80112233, 1'b0);
    chk("lbu_2003.value", bif.rdata, 32'h00000080);
    do_req("sh_3002", 1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000ABCD, 3, 32'h0, 1'b0);
    do_req("lw_4001", 1'b0, 2'd2, 1'b0, 32'h4001, 32'h0, 0, 32'h12345678, 1'b0);
    do_req("lh_neg", 1'b0, 2'd1, 1'b1, 32'h5002, 32'h0, 2, 32'h8001FFFF, 1'b1);
    do_req("size_ill", 1'b1, 2'd3, 1'b0, 32'h6000, 32'h55, 0, 32'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  sz;
      logic [31:0] addr;
      sz   = 2'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      do_req($sformatf("rnd%0d", n), 1'($urandom), sz, 1'($urandom), addr, $urandom,
             $urandom_range(0, 3), $urandom, 1'($urandom));
    end

    // Reset while a read is held by waitrequest.
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_size = 2'd2;
    bif.req_addr = 32'h7000; bif.avm_waitrequest = 1'b1;
    @(negedge clk);
    chk("rstmid.read_c1", 32'(bif.avm_read), 32'h1);
    @(negedge clk);
    chk("rstmid.read_c2", 32'(bif.avm_read), 32'h1);
    Rst = 1'b1;
    bif.req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid.read_dropped", 32'(bif.avm_read), 32'h0);
    chk("rstmid.no_ack", 32'(bif.ack), 32'h0);
    Rst = 1'b0;
    bif.avm_waitrequest = 1'b0;
    exp_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rstmid.idle_ack", 32'(bif.ack), 32'h0);
      chk("rstmid.idle_read", 32'(bif.avm_read), 32'h0);
    end
    do_req("after_rst", 1'b0, 2'd1, 1'b0, 32'h6006, 32'h0, 1, 32'hBEEF1234, 1'b0);

`ifdef MEM_BUS_CTRL_TIMEOUT_EN
    @(negedge clk);
    bif.req_valid = 1'b1; bif.req_write = 1'b0; bif.req_size = 2'd2;
    bif.req_addr = 32'h8000; bif.avm_waitrequest = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 4) begin
        chk("tmo.read_held", 32'(bif.avm_read), 32'h1);
        chk("tmo.no_ack", 32'(bif.ack), 32'h0);
      end else begin
        chk("tmo.ack", 32'(bif.ack), 32'h1);
        chk("tmo.bus_err", 32'(bif.bus_err), 32'h1);
        chk("tmo.req_err", 32'(bif.req_err), 32'h0);
        chk("tmo.read_dropped", 32'(bif.avm_read), 32'h0);
        chk("tmo.rdata_kept", bif.rdata, exp_rdata);
        bif.req_valid = 1'b0;
      end
    end
    bif.avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("tmo.ack_pulse", 32'(bif.ack), 32'h0);
    chk("tmo.bus_err_pulse", 32'(bif.bus_err), 32'h0);
    $display("txn timeout addr=8000 bus_err observed");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
